// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the LSU data-memory port arbiter: default
//   geometry of the dual-port data SRAM, the load-sequencer state encoding
//   and a helper that sizes requester-index fields.
//   Optional feature macro used by the arbiter: DMEM_ARB_FWD_EN.
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_MASK_W = DMEM_DATA_W / 8;
    localparam int DMEM_TAG_W  = 4;

    // Load sequencer: one read outstanding at a time.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_PEND = 2'd1,
        RESP    = 2'd2
    } state_e;

    // Width of a requester index; a single requester still gets one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Round-robin pick: the first asserted request at or above ptr_i, wrapping
//   around to index 0. Purely combinational.
//   Ports:
//     req_i  [N]      request vector
//     ptr_i  [IDX_W]  highest-priority index this cycle (must be < N)
//     gnt_o  [N]      one-hot winner (zero when no request)
//     idx_o  [IDX_W]  binary index of the winner (zero when no request)
//     any_o           at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import dmem_pkg::*;
#(
    parameter  int N     = 2,
    localparam int IDX_W = id_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    function automatic int wrap_idx(input int base, input int offs);
        int s;
        s = base + offs;
        if (s >= N) s = s - N;
        return s;
    endfunction

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'(wrap_idx(int'(ptr_i), i));
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the LSU data SRAM (port 0 write-only, port 1 read-only with one
//   cycle read latency) between NUM_LD round-robin load requesters and one
//   store requester. Stores are never stalled; a load whose address matches
//   the store accepted in the same cycle is held off for that cycle.
//   Load data returns over a valid/ready channel carrying requester id + tag.
//
//   Optional feature: define DMEM_ARB_FWD_EN to forward full-word store data
//   straight into the response buffer on a same-address collision instead
//   of stalling the load (partial-mask collisions still stall).
//
//   Ports:
//     clk_i, reset_n_i                 clock, synchronous active-low reset
//     ld_req_valid/addr/tag_i, ld_req_ready_o   load request channel (packed)
//     st_req_valid/addr/data/mask_i, st_req_ready_o  store request channel
//     ld_resp_valid/id/tag/data_o, ld_resp_ready_i   load response channel
//     dmem_csb_write_o, dmem_wmask_o, dmem_waddr_o, dmem_din_o  SRAM port 0
//     dmem_csb_read_o, dmem_raddr_o, dmem_dout_i                SRAM port 1
// ---------------------------------------------------------------------------
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter  int NUM_LD = 2,
    parameter  int ADDR_W = DMEM_ADDR_W,
    parameter  int DATA_W = DMEM_DATA_W,
    parameter  int TAG_W  = DMEM_TAG_W,
    localparam int MASK_W = DATA_W / 8,
    localparam int ID_W   = id_width(NUM_LD)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic [NUM_LD-1:0]        ld_req_valid_i,
    input  logic [NUM_LD*ADDR_W-1:0] ld_req_addr_i,
    input  logic [NUM_LD*TAG_W-1:0]  ld_req_tag_i,
    output logic [NUM_LD-1:0]        ld_req_ready_o,

    input  logic                     st_req_valid_i,
    input  logic [ADDR_W-1:0]        st_req_addr_i,
    input  logic [DATA_W-1:0]        st_req_data_i,
    input  logic [MASK_W-1:0]        st_req_mask_i,
    output logic                     st_req_ready_o,

    output logic                     ld_resp_valid_o,
    output logic [ID_W-1:0]          ld_resp_id_o,
    output logic [TAG_W-1:0]         ld_resp_tag_o,
    output logic [DATA_W-1:0]        ld_resp_data_o,
    input  logic                     ld_resp_ready_i,

    output logic                     dmem_csb_write_o,
    output logic [MASK_W-1:0]        dmem_wmask_o,
    output logic [ADDR_W-1:0]        dmem_waddr_o,
    output logic [DATA_W-1:0]        dmem_din_o,

    output logic                     dmem_csb_read_o,
    output logic [ADDR_W-1:0]        dmem_raddr_o,
    input  logic [DATA_W-1:0]        dmem_dout_i
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;

    logic [NUM_LD-1:0] arb_gnt;
    logic [ID_W-1:0]   arb_idx;
    logic              arb_any;

    logic              st_acc;
    logic              can_issue;
    logic              collide;
    logic              rd_issue;
    logic              fwd_issue;
    logic              grant;
    logic [ADDR_W-1:0] win_addr;
    logic [TAG_W-1:0]  win_tag;

    rr_arbiter #(
        .N (NUM_LD)
    ) u_rr (
        .req_i (ld_req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Issue decision. Only the round-robin winner is considered; if it
    // collides with the store, nobody is granted this cycle and the pointer
    // stays put so the same requester retries first.
    always_comb begin
        st_acc    = reset_n_i & st_req_valid_i;
        win_addr  = ld_req_addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];
        win_tag   = ld_req_tag_i[int'(arb_idx)*TAG_W +: TAG_W];
        can_issue = reset_n_i &&
                    ((state_q == IDLE) || ((state_q == RESP) && ld_resp_ready_i));
        collide   = st_acc && (win_addr == st_req_addr_i);
        rd_issue  = can_issue && arb_any && !collide;
`ifdef DMEM_ARB_FWD_EN
        fwd_issue = can_issue && arb_any && collide && (&st_req_mask_i);
`else
        fwd_issue = 1'b0;
`endif
        grant     = rd_issue || fwd_issue;
    end

    // Next state and response buffer. In RESP with ready low nothing can
    // issue, so the buffer holds id/tag/data stable until consumed.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        resp_id_d   = resp_id_q;
        resp_tag_d  = resp_tag_q;
        resp_data_d = resp_data_q;

        case (state_q)
            IDLE: begin
                if (rd_issue)       state_d = RD_PEND;
                else if (fwd_issue) state_d = RESP;
            end
            RD_PEND: begin
                state_d     = RESP;
                resp_data_d = dmem_dout_i;
            end
            RESP: begin
                if (rd_issue)             state_d = RD_PEND;
                else if (fwd_issue)       state_d = RESP;
                else if (ld_resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (grant) begin
            resp_id_d  = arb_idx;
            resp_tag_d = win_tag;
            rr_ptr_d   = (arb_idx == ID_W'(NUM_LD - 1)) ? '0 : arb_idx + 1'b1;
        end
        if (fwd_issue) begin
            resp_data_d = st_req_data_i;
        end
    end

    // Outputs. Everything is gated by reset_n_i so the SRAM sees both ports
    // deselected and requesters see no grants while reset is held.
    always_comb begin
        ld_req_ready_o   = grant ? arb_gnt : '0;
        st_req_ready_o   = reset_n_i;

        ld_resp_valid_o  = reset_n_i && (state_q == RESP);
        ld_resp_id_o     = resp_id_q;
        ld_resp_tag_o    = resp_tag_q;
        ld_resp_data_o   = resp_data_q;

        dmem_csb_write_o = ~st_acc;
        dmem_wmask_o     = st_acc ? st_req_mask_i : '0;
        dmem_waddr_o     = st_acc ? st_req_addr_i : '0;
        dmem_din_o       = st_acc ? st_req_data_i : '0;

        dmem_csb_read_o  = ~rd_issue;
        dmem_raddr_o     = rd_issue ? win_addr : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Response payload needs no reset: it is only observed while valid.
    always_ff @(posedge clk_i) begin
        resp_id_q   <= resp_id_d;
        resp_tag_q  <= resp_tag_d;
        resp_data_q <= resp_data_d;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    localparam int NUM_LD = 2;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int MASK_W = DATA_W / 8;
    localparam int ID_W   = 1;

`ifdef DMEM_ARB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset_n;
    logic [NUM_LD-1:0]        ld_valid;
    logic [ADDR_W-1:0]        la [NUM_LD];
    logic [TAG_W-1:0]         lt [NUM_LD];
    logic [NUM_LD*ADDR_W-1:0] ld_addr_pk;
    logic [NUM_LD*TAG_W-1:0]  ld_tag_pk;
    logic [NUM_LD-1:0]        ld_ready;
    logic                     st_valid;
    logic [ADDR_W-1:0]        st_addr;
    logic [DATA_W-1:0]        st_data;
    logic [MASK_W-1:0]        st_mask;
    logic                     st_ready;
    logic                     resp_valid;
    logic [ID_W-1:0]          resp_id;
    logic [TAG_W-1:0]         resp_tag;
    logic [DATA_W-1:0]        resp_data;
    logic                     resp_ready;
    logic                     csb_write;
    logic [MASK_W-1:0]        wmask;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        din;
    logic                     csb_read;
    logic [ADDR_W-1:0]        raddr;
    logic [DATA_W-1:0]        dout = '0;

    always_comb begin
        ld_addr_pk = '0;
        ld_tag_pk  = '0;
        for (int i = 0; i < NUM_LD; i++) begin
            ld_addr_pk[i*ADDR_W +: ADDR_W] = la[i];
            ld_tag_pk[i*TAG_W +: TAG_W]    = lt[i];
        end
    end

    dmem_port_arbiter #(
        .NUM_LD (NUM_LD),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .ld_req_valid_i   (ld_valid),
        .ld_req_addr_i    (ld_addr_pk),
        .ld_req_tag_i     (ld_tag_pk),
        .ld_req_ready_o   (ld_ready),
        .st_req_valid_i   (st_valid),
        .st_req_addr_i    (st_addr),
        .st_req_data_i    (st_data),
        .st_req_mask_i    (st_mask),
        .st_req_ready_o   (st_ready),
        .ld_resp_valid_o  (resp_valid),
        .ld_resp_id_o     (resp_id),
        .ld_resp_tag_o    (resp_tag),
        .ld_resp_data_o   (resp_data),
        .ld_resp_ready_i  (resp_ready),
        .dmem_csb_write_o (csb_write),
        .dmem_wmask_o     (wmask),
        .dmem_waddr_o     (waddr),
        .dmem_din_o       (din),
        .dmem_csb_read_o  (csb_read),
        .dmem_raddr_o     (raddr),
        .dmem_dout_i      (dout)
    );

    // SRAM stand-in: byte-masked write port, registered read port.
    logic [DATA_W-1:0] sram [256] = '{default: '0};
    always @(posedge clk) begin
        if (!csb_write) begin
            for (int b = 0; b < MASK_W; b++)
                if (wmask[b]) sram[waddr][b*8 +: 8] <= din[b*8 +: 8];
        end
        if (!csb_read) dout <= sram[raddr];
    end

    // Reference model state: memory contents as seen by the program, and
    // the single outstanding load (when it becomes visible and what it holds).
    logic [DATA_W-1:0] ref_mem [256] = '{default: '0};
    bit                have_ld;
    int                ld_resp_cyc;
    int                exp_id;
    logic [TAG_W-1:0]  exp_tag;
    logic [DATA_W-1:0] exp_data;
    int                rr;
    int                cyc;
    int                checks;
    int                errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs for the inputs currently applied,
    // advance the model, then step to just after the next rising edge.
    task automatic tick();
        int w;
        bit anyv, pres, can, coll, gnt, rd;
        logic [ADDR_W-1:0] wa;
        #2;
        if (!reset_n) begin
            chk("rst_ld_ready", ld_ready, 0);
            chk("rst_st_ready", st_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_csb_write", csb_write, 1);
            chk("rst_csb_read", csb_read, 1);
            chk("rst_wmask", wmask, 0);
            chk("rst_waddr", waddr, 0);
            chk("rst_din", din, 0);
            have_ld = 1'b0;
            rr      = 0;
        end else begin
            pres = have_ld && (cyc >= ld_resp_cyc);
            chk("resp_valid", resp_valid, pres);
            if (pres) begin
                chk("resp_id", resp_id, exp_id);
                chk("resp_tag", resp_tag, exp_tag);
                chk("resp_data", resp_data, exp_data);
            end
            chk("st_ready", st_ready, 1);
            chk("csb_write", csb_write, !st_valid);
            chk("wmask", wmask, st_valid ? st_mask : '0);
            chk("waddr", waddr, st_valid ? st_addr : '0);
            chk("din", din, st_valid ? st_data : '0);

            can  = !have_ld || (pres && resp_ready);
            anyv = 1'b0;
            w    = 0;
            for (int k = 0; k < NUM_LD; k++) begin
                if (!anyv && ld_valid[(rr + k) % NUM_LD]) begin
                    anyv = 1'b1;
                    w    = (rr + k) % NUM_LD;
                end
            end
            wa  = la[w];
            gnt = 1'b0;
            rd  = 1'b0;
            if (can && anyv) begin
                coll = st_valid && (wa == st_addr);
                if (!coll) begin
                    gnt = 1'b1;
                    rd  = 1'b1;
                end else if (FWD && (st_mask == '1)) begin
                    gnt = 1'b1;
                end
            end
            chk("ld_ready", ld_ready, gnt ? (64'd1 << w) : 64'd0);
            chk("csb_read", csb_read, !rd);
            chk("raddr", raddr, rd ? wa : '0);

            if (pres && resp_ready) have_ld = 1'b0;
            if (gnt) begin
                have_ld     = 1'b1;
                ld_resp_cyc = cyc + (rd ? 2 : 1);
                exp_id      = w;
                exp_tag     = lt[w];
                exp_data    = rd ? ref_mem[wa] : st_data;
                rr          = (w + 1) % NUM_LD;
            end
            if (st_valid) begin
                for (int b = 0; b < MASK_W; b++)
                    if (st_mask[b]) ref_mem[st_addr][b*8 +: 8] = st_data[b*8 +: 8];
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ld_valid = '0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_mask  = '0;
        for (int i = 0; i < NUM_LD; i++) begin
            la[i] = '0;
            lt[i] = '0;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        rr         = 0;
        have_ld    = 1'b0;
        reset_n    = 1'b0;
        resp_ready = 1'b1;
        quiet();

        // Reset, including requests presented while reset is held.
        tick();
        ld_valid = 2'b11; st_valid = 1'b1; st_addr = 8'h05; st_data = 32'hA5A5A5A5; st_mask = 4'hF;
        tick();
        quiet();
        reset_n = 1'b1;
        tick();

        // Store then load of the same word.
        st_valid = 1'b1; st_addr = 8'h10; st_data = 32'hDEADBEEF; st_mask = 4'hF;
        tick();
        quiet();
        ld_valid = 2'b01; la[0] = 8'h10; lt[0] = 4'h5;
        tick();
        quiet();
        tick();
        chk("t1_valid", resp_valid, 1);
        chk("t1_id", resp_id, 0);
        chk("t1_data", resp_data, 32'hDEADBEEF);
        tick();

        // Two requesters streaming: grants alternate.
        ld_valid = 2'b11; la[0] = 8'h10; la[1] = 8'h11; lt[0] = 4'h1; lt[1] = 4'h2;
        for (int i = 0; i < 10; i++) tick();
        quiet();
        tick(); tick();

        // Same-cycle store/load collision, full mask.
        ld_valid = 2'b01; la[0] = 8'h20; lt[0] = 4'h7;
        st_valid = 1'b1; st_addr = 8'h20; st_data = 32'hCAFEF00D; st_mask = 4'hF;
        tick();
        st_valid = 1'b0;
        tick();
        ld_valid = '0;
        tick(); tick(); tick();

        // Partial-mask collision always stalls.
        ld_valid = 2'b10; la[1] = 8'h20; lt[1] = 4'h9;
        st_valid = 1'b1; st_addr = 8'h20; st_data = 32'h12345678; st_mask = 4'h3;
        tick();
        st_valid = 1'b0;
        tick();
        ld_valid = '0;
        tick(); tick(); tick();

        // Forward candidate: full mask collision.
        ld_valid = 2'b01; la[0] = 8'h22; lt[0] = 4'hA;
        st_valid = 1'b1; st_addr = 8'h22; st_data = 32'h12345678; st_mask = 4'hF;
        tick();
        st_valid = 1'b0;
        tick();
        ld_valid = '0;
        tick(); tick(); tick();

        // Consumer back-pressure with a second request waiting.
        resp_ready = 1'b0;
        ld_valid = 2'b01; la[0] = 8'h11; lt[0] = 4'h3;
        tick();
        ld_valid = 2'b10; la[1] = 8'h10; lt[1] = 4'h4;
        for (int i = 0; i < 7; i++) tick();
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        quiet();
        tick(); tick();

        // Reset while a read is pending; pointer must return to requester 0.
        ld_valid = 2'b01; la[0] = 8'h10; lt[0] = 4'h6;
        tick();
        quiet();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        ld_valid = 2'b11; la[0] = 8'h30; la[1] = 8'h31;
        #2;
        chk("t6_rr_reset", ld_ready, 2'b01);
        tick();
        quiet();
        tick(); tick(); tick();

        // Randomised traffic over a small address window to provoke collisions.
        for (int n = 0; n < 800; n++) begin
            reset_n    = ($urandom_range(0, 99) != 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_LD; i++) begin
                ld_valid[i] = $urandom_range(0, 2) != 0;
                la[i]       = 8'($urandom_range(0, 7));
                lt[i]       = 4'($urandom);
            end
            st_valid = $urandom_range(0, 1) != 0;
            st_addr  = 8'($urandom_range(0, 7));
            st_data  = $urandom;
            st_mask  = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
